// File: rtl/text_cursor_ctrl_if.sv
// Byte-stream input and character-RAM write bus of the text cursor controller.
// master = byte source / RAM-side observer, slave = text_cursor_ctrl.
interface text_cursor_ctrl_if #(
    parameter int CW = 7,
    parameter int RW = 6
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] tab_out;
    logic [CW-1:0] str_out;
    logic [7:0]    wr_data;
    logic          wr_en;

    modport master (
        output in_data, in_valid,
        input  in_ready, tab_out, str_out, wr_data, wr_en
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tab_out, str_out, wr_data, wr_en
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Turns a byte stream into row/column writes for the character RAM, with wrap, LF/CR,
// per-row clear and full clear after reset. Optional feature macro: BACKSPACE_EN.
module text_cursor_ctrl #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 48,
    parameter logic [7:0] CLR_CHAR = 8'h00,
    localparam int        CW       = $clog2(COLS),
    localparam int        RW       = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    text_cursor_ctrl_if.slave   bus,
    output logic [RW-1:0]       cur_tab,
    output logic [CW-1:0]       cur_str,
    output logic                busy
);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {INIT_CLR, IDLE, ROW_CLR} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] cur_tab_nxt, clr_row, clr_row_nxt, tab_nxt;
    logic [CW-1:0] cur_str_nxt, clr_col, clr_col_nxt, str_nxt;
    logic [7:0]    data_nxt;
    logic          wr_nxt;
    logic          printable;

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == ROW_LAST) ? '0 : r + RW'(1);
    endfunction

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign printable    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    always_comb begin
        state_nxt   = state;
        cur_tab_nxt = cur_tab;
        cur_str_nxt = cur_str;
        clr_row_nxt = clr_row;
        clr_col_nxt = clr_col;
        wr_nxt      = 1'b0;
        tab_nxt     = bus.tab_out;
        str_nxt     = bus.str_out;
        data_nxt    = bus.wr_data;
        case (state)
            INIT_CLR: begin
                wr_nxt   = 1'b1;
                tab_nxt  = clr_row;
                str_nxt  = clr_col;
                data_nxt = CLR_CHAR;
                if (clr_col == COL_LAST) begin
                    clr_col_nxt = '0;
                    if (clr_row == ROW_LAST) begin
                        clr_row_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        clr_row_nxt = clr_row + RW'(1);
                    end
                end else begin
                    clr_col_nxt = clr_col + CW'(1);
                end
            end
            // cur_tab already points at the freshly entered row
            ROW_CLR: begin
                wr_nxt   = 1'b1;
                tab_nxt  = cur_tab;
                str_nxt  = clr_col;
                data_nxt = CLR_CHAR;
                if (clr_col == COL_LAST) begin
                    clr_col_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    clr_col_nxt = clr_col + CW'(1);
                end
            end
            IDLE: begin
                clr_col_nxt = '0;
                if (bus.in_valid) begin
                    if (printable) begin
                        wr_nxt   = 1'b1;
                        tab_nxt  = cur_tab;
                        str_nxt  = cur_str;
                        data_nxt = bus.in_data;
                        if (cur_str == COL_LAST) begin
                            cur_str_nxt = '0;
                            cur_tab_nxt = next_row(cur_tab);
                            state_nxt   = ROW_CLR;
                        end else begin
                            cur_str_nxt = cur_str + CW'(1);
                        end
                    end else if (bus.in_data == 8'h0A) begin
                        cur_str_nxt = '0;
                        cur_tab_nxt = next_row(cur_tab);
                        state_nxt   = ROW_CLR;
                    end else if (bus.in_data == 8'h0D) begin
                        cur_str_nxt = '0;
`ifdef BACKSPACE_EN
                    end else if (bus.in_data == 8'h08 && cur_str != '0) begin
                        cur_str_nxt = cur_str - CW'(1);
                        wr_nxt      = 1'b1;
                        tab_nxt     = cur_tab;
                        str_nxt     = cur_str - CW'(1);
                        data_nxt    = CLR_CHAR;
`endif
                    end
                end
            end
            default: state_nxt = INIT_CLR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT_CLR;
            cur_tab     <= '0;
            cur_str     <= '0;
            clr_row     <= '0;
            clr_col     <= '0;
            bus.wr_en   <= 1'b0;
            bus.tab_out <= '0;
            bus.str_out <= '0;
            bus.wr_data <= CLR_CHAR;
        end else begin
            state       <= state_nxt;
            cur_tab     <= cur_tab_nxt;
            cur_str     <= cur_str_nxt;
            clr_row     <= clr_row_nxt;
            clr_col     <= clr_col_nxt;
            bus.wr_en   <= wr_nxt;
            bus.tab_out <= tab_nxt;
            bus.str_out <= str_nxt;
            bus.wr_data <= data_nxt;
        end
    end
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed + random bench for text_cursor_ctrl; every RAM write is matched against a
// queue of expected (row, col, data, cycle) entries built from the cursor rules.
module tb_text_cursor_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 48;

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cur_tab;
    logic [6:0] cur_str;
    logic       busy;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         mrow  = 0;
    int         mcol  = 0;
    wr_t        exp_q[$];
    wr_t        e;

    text_cursor_ctrl_if #(.CW(7), .RW(6)) bus ();

    text_cursor_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cur_tab (cur_tab),
        .cur_str (cur_str),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("wr_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_row", bus.tab_out, e.row);
                chk("wr_col", bus.str_out, e.col);
                chk("wr_data", bus.wr_data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_row_clear(input int row, input int c);
        for (int k = 0; k < COLS; k++) exp_q.push_back('{row, k, 0, c + 2 + k});
    endtask

    // c = cycle count seen at the negedge just before the accepting edge
    task automatic model_byte(input logic [7:0] b, input int c);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back('{mrow, mcol, int'(b), c + 1});
            if (mcol < COLS - 1) begin
                mcol++;
            end else begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
                push_row_clear(mrow, c);
            end
        end else if (b == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
            push_row_clear(mrow, c);
        end else if (b == 8'h0D) begin
            mcol = 0;
`ifdef BACKSPACE_EN
        end else if (b == 8'h08 && mcol > 0) begin
            mcol--;
            exp_q.push_back('{mrow, mcol, 0, c + 1});
`endif
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("accept_timeout", n, 0);
        model_byte(b, cyc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("cur_tab", cur_tab, mrow);
        chk("cur_str", cur_str, mcol);
    endtask

    task automatic drain();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic busy_len(input int expv);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, expv);
    endtask

    task automatic check_reset_state();
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_tab_out", bus.tab_out, 0);
        chk("rst_str_out", bus.str_out, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_cur_tab", cur_tab, 0);
        chk("rst_cur_str", cur_str, 0);
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", bus.in_ready, 0);
    endtask

    task automatic release_and_init();
        int n = 0;
        @(negedge clk);
        rst  = 1'b0;
        mrow = 0;
        mcol = 0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                exp_q.push_back('{r, k, 0, cyc + 1 + r * COLS + k});
        while (bus.in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("init_cycles", n, ROWS * COLS);
        @(negedge clk);
        chk("init_queue", exp_q.size(), 0);
        chk("init_cur_tab", cur_tab, 0);
        chk("init_cur_str", cur_str, 0);
        chk("init_busy", busy, 0);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;

        // power-on reset and full clear
        repeat (3) @(negedge clk);
        check_reset_state();
        release_and_init();

        // back-to-back printable bytes
        send(8'h41);
        send(8'h42);
        chk("ab_cur_str", cur_str, 2);
        drain();

        // full row from column 0, wrap into row 1
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'h41);
        busy_len(COLS);
        drain();
        chk("wrap_cur_tab", cur_tab, 1);
        chk("wrap_cur_str", cur_str, 0);

        // LF from the last row wraps to row 0
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(rand_print());
        chk("pre_lf_cur_tab", cur_tab, ROWS - 1);
        chk("pre_lf_cur_str", cur_str, 5);
        send(8'h0A);
        busy_len(COLS);
        drain();
        chk("lf_wrap_cur_tab", cur_tab, 0);
        chk("lf_wrap_cur_str", cur_str, 0);

        // CR and a dropped control byte
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(rand_print());
        send(8'h0D);
        chk("cr_cur_tab", cur_tab, 3);
        chk("cr_cur_str", cur_str, 0);
        send(8'h07);
        chk("bel_cur_tab", cur_tab, 3);
        chk("bel_cur_str", cur_str, 0);
        drain();

        // random byte mix with idle gaps
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            case (r)
                0:       b = 8'h0A;
                1:       b = 8'h0D;
                2:       b = 8'h08;
                3:       b = 8'($urandom_range(0, 255));
                default: b = rand_print();
            endcase
            send(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // reset in the middle of a row clear
        send(8'h0A);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_state();
        repeat (2) @(negedge clk);
        release_and_init();

        // backspace handling (dropped byte when the feature is off)
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 4; i++) send(rand_print());
        send(8'h08);
        drain();
`ifdef BACKSPACE_EN
        chk("bs_cur_str", cur_str, 3);
`else
        chk("bs_cur_str", cur_str, 4);
`endif
        chk("bs_cur_tab", cur_tab, 2);
        send(8'h0D);
        send(8'h08);
        drain();
        chk("bs_col0_cur_tab", cur_tab, 2);
        chk("bs_col0_cur_str", cur_str, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
